pong_frame_engine: RTL

- Game-state and raster source for the 240x135 SPI LCD pixel streamer.
- Sits directly upstream of the streamer. Advances ball/paddle physics once per frame on the streamer's end-of-frame pulse.
- Tracks the raster position as the streamer consumes pixels, and returns a 1-bit on/off pixel for the current raster position.
- Exposes a hit score for the BCD/digit overlay.

---
 rtl/pong_frame_engine.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pong_frame_engine.sv
// Pong game state and 1-bit raster source for the 240x135 LCD streamer.
// Define PONG_AUTO_PADDLE_EN to let the paddle chase the ball instead of the buttons.
`timescale 1ns/1ps
module pong_frame_engine #(
    parameter int H_RES        = 240,
    parameter int V_RES        = 135,
    parameter int PADDLE_X     = 8,
    parameter int PADDLE_W     = 4,
    parameter int PADDLE_H     = 24,
    parameter int PADDLE_STEP  = 2,
    parameter int BALL_SIZE    = 4,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       pixel_adv,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       pixel,
    output logic [7:0] score,
    output logic [1:0] game_state
);
    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;

    localparam logic [7:0] X_LAST     = 8'(H_RES - 1);
    localparam logic [7:0] Y_LAST     = 8'(V_RES - 1);
    localparam logic [7:0] BX0        = 8'((H_RES - BALL_SIZE) / 2);
    localparam logic [7:0] BY0        = 8'((V_RES - BALL_SIZE) / 2);
    localparam logic [7:0] PY0        = 8'((V_RES - PADDLE_H) / 2);
    localparam logic [7:0] PY_MAX     = 8'(V_RES - PADDLE_H);
    localparam logic [7:0] BY_MAX     = 8'(V_RES - BALL_SIZE);
    localparam logic [7:0] BX_WALL    = 8'(H_RES - BALL_SIZE);
    localparam logic [7:0] WALL_TURN  = 8'(H_RES - BALL_SIZE - BALL_SPEED);
    localparam logic [7:0] BX_FACE    = 8'(PADDLE_X + PADDLE_W);
    localparam logic [7:0] FACE_TURN  = 8'(PADDLE_X + PADDLE_W + BALL_SPEED);
    localparam logic [7:0] STEP       = 8'(PADDLE_STEP);
    localparam logic [7:0] SPEED      = 8'(BALL_SPEED);
    localparam logic [7:0] SCORE_MAX  = 8'd99;
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);
    localparam logic [8:0] PX_LO      = 9'(PADDLE_X);
    localparam logic [8:0] PX_HI      = 9'(PADDLE_X + PADDLE_W);
    localparam logic [8:0] PH9        = 9'(PADDLE_H);
    localparam logic [8:0] BS9        = 9'(BALL_SIZE);

    state_t     state;
    logic [1:0] up_sync, down_sync;
    logic [7:0] x, y, bx, by, py, fc;
    logic       vx_neg, vy_neg, serve_dir;
    logic [8:0] x9, y9, bx9, by9, py9;
    logic       paddle_hit, ball_hit, overlap;
    logic       move_up, move_down;
    logic [7:0] py_next, by_next;
    logic       vy_neg_next;

    assign x9  = {1'b0, x};
    assign y9  = {1'b0, y};
    assign bx9 = {1'b0, bx};
    assign by9 = {1'b0, by};
    assign py9 = {1'b0, py};

    assign paddle_hit = (x9 >= PX_LO) && (x9 < PX_HI) && (y9 >= py9) && (y9 < py9 + PH9);
    assign ball_hit   = (x9 >= bx9) && (x9 < bx9 + BS9) && (y9 >= by9) && (y9 < by9 + BS9);
    assign overlap    = (by9 < py9 + PH9) && (py9 < by9 + BS9);
    assign pixel      = paddle_hit | (ball_hit & (state != MISS));
    assign game_state = state;

`ifdef PONG_AUTO_PADDLE_EN
    logic [8:0] ball_mid, pad_mid;
    assign ball_mid  = by9 + 9'(BALL_SIZE / 2);
    assign pad_mid   = py9 + 9'(PADDLE_H / 2);
    assign move_up   = ball_mid < pad_mid;
    assign move_down = ball_mid > pad_mid;
`else
    assign move_up   = up_sync[1] & ~down_sync[1];
    assign move_down = down_sync[1] & ~up_sync[1];
`endif

    always_comb begin
        py_next = py;
        if (move_up)
            py_next = (py < STEP) ? 8'd0 : py - STEP;
        else if (move_down)
            py_next = (py > PY_MAX - STEP) ? PY_MAX : py + STEP;
    end

    always_comb begin
        by_next     = vy_neg ? by - 8'd1 : by + 8'd1;
        vy_neg_next = vy_neg;
        if (vy_neg && by == 8'd0) begin
            by_next     = 8'd1;
            vy_neg_next = 1'b0;
        end else if (!vy_neg && by == BY_MAX) begin
            by_next     = by - 8'd1;
            vy_neg_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_sync   <= 2'b00;
            down_sync <= 2'b00;
        end else begin
            up_sync   <= {up_sync[0], btn_up};
            down_sync <= {down_sync[0], btn_down};
        end
    end

    // The last pixel of a frame is sticky until the streamer signals frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= 8'd0;
            y <= 8'd0;
        end else if (frame_tick) begin
            x <= 8'd0;
            y <= 8'd0;
        end else if (pixel_adv) begin
            if (x == X_LAST) begin
                if (y != Y_LAST) begin
                    x <= 8'd0;
                    y <= y + 8'd1;
                end
            end else begin
                x <= x + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SERVE;
            fc        <= 8'd0;
            serve_dir <= 1'b0;
            py        <= PY0;
            bx        <= BX0;
            by        <= BY0;
            vx_neg    <= 1'b0;
            vy_neg    <= 1'b0;
            score     <= 8'd0;
        end else if (frame_tick) begin
            py <= py_next;
            unique case (state)
                SERVE: begin
                    bx <= BX0;
                    by <= BY0;
                    if (fc == SERVE_LAST) begin
                        fc        <= 8'd0;
                        state     <= PLAY;
                        vx_neg    <= 1'b0;
                        vy_neg    <= serve_dir;
                        serve_dir <= ~serve_dir;
                    end else begin
                        fc <= fc + 8'd1;
                    end
                end
                PLAY: begin
                    if (!vx_neg && bx >= WALL_TURN) begin
                        bx     <= BX_WALL;
                        vx_neg <= 1'b1;
                        by     <= by_next;
                        vy_neg <= vy_neg_next;
                    end else if (vx_neg && bx <= FACE_TURN) begin
                        if (overlap) begin
                            bx     <= BX_FACE;
                            vx_neg <= 1'b0;
                            score  <= (score < SCORE_MAX) ? score + 8'd1 : SCORE_MAX;
                            by     <= by_next;
                            vy_neg <= vy_neg_next;
                        end else begin
                            // Ball freezes where it was missed; it stays hidden until serve.
                            state <= MISS;
                            fc    <= 8'd0;
                        end
                    end else begin
                        bx     <= vx_neg ? bx - SPEED : bx + SPEED;
                        by     <= by_next;
                        vy_neg <= vy_neg_next;
                    end
                end
                MISS: begin
                    if (fc == MISS_LAST) begin
                        fc    <= 8'd0;
                        score <= 8'd0;
                        state <= SERVE;
                        bx    <= BX0;
                        by    <= BY0;
                    end else begin
                        fc <= fc + 8'd1;
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end
endmodule
